// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and default widths for the SRAM arbiter slice.
//   state_t : access sequencer states
//   grant_t : which requester owns the current SRAM access
// ---------------------------------------------------------------------------
package sram_arb_pkg;

   localparam int ADDR_W_DEF      = 20;
   localparam int DATA_W_DEF      = 16;
   localparam int WAIT_CYCLES_DEF = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef enum logic {
      G_CPU = 1'b0,
      G_AUX = 1'b1
   } grant_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// ---------------------------------------------------------------------------
// sram_rr_arb2
// Two-way round-robin pick between the CPU and the auxiliary requester.
// The pick is combinational from the request lines; the last_grant pointer
// is registered and only advances when a tie is resolved.
//   Clk, Reset   : clock, synchronous active-high reset
//   i_req_cpu    : CPU request level
//   i_req_aux    : AUX request level
//   i_take       : sequencer is idle and will accept the pick this cycle
//   o_any        : at least one request is pending
//   o_gnt_aux    : 1 = pick AUX, 0 = pick CPU
// ---------------------------------------------------------------------------
module sram_rr_arb2
   import sram_arb_pkg::*;
(
   input  logic Clk,
   input  logic Reset,
   input  logic i_req_cpu,
   input  logic i_req_aux,
   input  logic i_take,
   output logic o_any,
   output logic o_gnt_aux
);

   grant_t r_last;
   grant_t w_gnt;
   logic   w_tie;

   assign w_tie     = i_req_cpu & i_req_aux;
   assign o_any     = i_req_cpu | i_req_aux;
   assign o_gnt_aux = (w_gnt == G_AUX);

   always_comb begin
      w_gnt = G_CPU;
      if (w_tie)
         w_gnt = (r_last == G_AUX) ? G_CPU : G_AUX;
      else if (i_req_aux)
         w_gnt = G_AUX;
   end

   // Only contested grants move the pointer. A lone requester does not
   // "use up" its turn, so the loser of the last tie still wins the next one.
   // Reset to AUX so the CPU wins the first tie.
   always_ff @(posedge Clk) begin
      if (Reset)
         r_last <= G_AUX;
      else if (i_take && w_tie)
         r_last <= w_gnt;
   end

endmodule

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Shares one asynchronous SRAM port between the CPU datapath and an
// auxiliary port using a level req / one-cycle ack handshake, and sequences
// the chip strobes with WAIT_CYCLES strobe cycles per access
// (WAIT_CYCLES must be >= 1).
//   Clk, Reset          : clock, synchronous active-high reset
//   i_cpu_* / o_cpu_*   : CPU request (req, we, addr, wdata) and ack/rdata
//   i_aux_* / o_aux_*   : auxiliary request and ack/rdata, same protocol
//   o_sram_addr/_wdata  : address and write data to the pads
//   i_sram_rdata        : read data from the pads
//   o_sram_data_oe      : pad data driver enable
//   o_sram_ce_n/_oe_n/_we_n : active-low SRAM strobes
// Timeline: req sampled in IDLE (cycle 0), strobes active cycles
// 1..WAIT_CYCLES, ack in cycle WAIT_CYCLES+1. Every pad-facing output
// comes straight from a register.
// ---------------------------------------------------------------------------
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
)(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ack,
   output logic [DATA_W-1:0] o_cpu_rdata,
   input  logic              i_aux_req,
   input  logic              i_aux_we,
   input  logic [ADDR_W-1:0] i_aux_addr,
   input  logic [DATA_W-1:0] i_aux_wdata,
   output logic              o_aux_ack,
   output logic [DATA_W-1:0] o_aux_rdata,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_wdata,
   input  logic [DATA_W-1:0] i_sram_rdata,
   output logic              o_sram_data_oe,
   output logic              o_sram_ce_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n
);

   localparam int                CNT_W    = $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_t              r_state;
   grant_t              r_gnt;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_ce_n, r_oe_n, r_we_n, r_doe;
   logic                r_cpu_ack, r_aux_ack;
   logic [DATA_W-1:0]   r_cpu_rdata, r_aux_rdata;

   logic                w_idle, w_any, w_gnt_aux;
   logic                w_we;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_wdata;

   assign w_idle = (r_state == IDLE);

   sram_rr_arb2 u_rr (
      .Clk       (Clk),
      .Reset     (Reset),
      .i_req_cpu (i_cpu_req),
      .i_req_aux (i_aux_req),
      .i_take    (w_idle),
      .o_any     (w_any),
      .o_gnt_aux (w_gnt_aux)
   );

   // Request fields of the winner, latched on grant
   assign w_we    = w_gnt_aux ? i_aux_we    : i_cpu_we;
   assign w_addr  = w_gnt_aux ? i_aux_addr  : i_cpu_addr;
   assign w_wdata = w_gnt_aux ? i_aux_wdata : i_cpu_wdata;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_gnt       <= G_CPU;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_ce_n      <= 1'b1;
         r_oe_n      <= 1'b1;
         r_we_n      <= 1'b1;
         r_doe       <= 1'b0;
         r_cpu_ack   <= 1'b0;
         r_aux_ack   <= 1'b0;
         r_cpu_rdata <= '0;
         r_aux_rdata <= '0;
      end else begin
         r_cpu_ack <= 1'b0;
         r_aux_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt   <= w_gnt_aux ? G_AUX : G_CPU;
                  r_we    <= w_we;
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  r_cnt   <= CNT_LOAD;
                  // Strobes are set here so they are active from cycle 1
                  r_ce_n  <= 1'b0;
                  r_oe_n  <= w_we;
                  r_we_n  <= ~w_we;
                  r_doe   <= w_we;
                  r_state <= ACCESS;
               end
            end
            ACCESS: begin
               if (r_cnt == '0) begin
                  r_ce_n <= 1'b1;
                  r_oe_n <= 1'b1;
                  r_we_n <= 1'b1;
                  // r_doe stays set through DONE so write data is held
                  // past the rising edge of we_n.
                  if (!r_we) begin
                     if (r_gnt == G_AUX) r_aux_rdata <= i_sram_rdata;
                     else                r_cpu_rdata <= i_sram_rdata;
                  end
                  if (r_gnt == G_AUX) r_aux_ack <= 1'b1;
                  else                r_cpu_ack <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            DONE: begin
               r_doe   <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_cpu_ack      = r_cpu_ack;
   assign o_aux_ack      = r_aux_ack;
   assign o_cpu_rdata    = r_cpu_rdata;
   assign o_aux_rdata    = r_aux_rdata;
   assign o_sram_addr    = r_addr;
   assign o_sram_wdata   = r_wdata;
   assign o_sram_data_oe = r_doe;
   assign o_sram_ce_n    = r_ce_n;
   assign o_sram_oe_n    = r_oe_n;
   assign o_sram_we_n    = r_we_n;

   a_ack_excl: assert property (@(posedge Clk) disable iff (Reset)
      !(o_cpu_ack && o_aux_ack));
   a_oe_we_excl: assert property (@(posedge Clk) disable iff (Reset)
      !(!o_sram_oe_n && !o_sram_we_n));
   a_ack_in_done: assert property (@(posedge Clk) disable iff (Reset)
      (o_cpu_ack || o_aux_ack) |-> (r_state == DONE));

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Directed bench for sram_arbiter: a table of single transactions, hand
// sequences for ties, mid-access reset and a WAIT_CYCLES=1 build, and a
// random two-port phase scored against a reference memory.
// SRAM model: 256 words aliased on addr[7:0], reloaded on Reset.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

   logic        Clk, Reset;
   logic        cpu_req, cpu_we, cpu_ack, aux_req, aux_we, aux_ack;
   logic [19:0] cpu_addr, aux_addr, sram_addr;
   logic [15:0] cpu_wdata, aux_wdata, cpu_rdata, aux_rdata;
   logic [15:0] sram_wdata, sram_rdata;
   logic        sram_data_oe, ce_n, oe_n, we_n;

   // WAIT_CYCLES=1 instance (CPU port only used)
   logic        d1_cpu_req, d1_cpu_we, d1_cpu_ack, d1_aux_req, d1_aux_we, d1_aux_ack;
   logic [19:0] d1_cpu_addr, d1_aux_addr, d1_sram_addr;
   logic [15:0] d1_cpu_wdata, d1_aux_wdata, d1_cpu_rdata, d1_aux_rdata;
   logic [15:0] d1_sram_wdata, d1_sram_rdata;
   logic        d1_doe, d1_ce_n, d1_oe_n, d1_we_n;

   int checks = 0;
   int errors = 0;
   int n_overlap = 0;
   int n_rw = 0;

   logic [15:0] mem [0:255];

   sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(3)) u_dut (
      .Clk(Clk), .Reset(Reset),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
      .i_aux_req(aux_req), .i_aux_we(aux_we), .i_aux_addr(aux_addr), .i_aux_wdata(aux_wdata),
      .o_aux_ack(aux_ack), .o_aux_rdata(aux_rdata),
      .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata),
      .o_sram_data_oe(sram_data_oe), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n)
   );

   sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1)) u_dut1 (
      .Clk(Clk), .Reset(Reset),
      .i_cpu_req(d1_cpu_req), .i_cpu_we(d1_cpu_we), .i_cpu_addr(d1_cpu_addr), .i_cpu_wdata(d1_cpu_wdata),
      .o_cpu_ack(d1_cpu_ack), .o_cpu_rdata(d1_cpu_rdata),
      .i_aux_req(d1_aux_req), .i_aux_we(d1_aux_we), .i_aux_addr(d1_aux_addr), .i_aux_wdata(d1_aux_wdata),
      .o_aux_ack(d1_aux_ack), .o_aux_rdata(d1_aux_rdata),
      .o_sram_addr(d1_sram_addr), .o_sram_wdata(d1_sram_wdata), .i_sram_rdata(d1_sram_rdata),
      .o_sram_data_oe(d1_doe), .o_sram_ce_n(d1_ce_n), .o_sram_oe_n(d1_oe_n), .o_sram_we_n(d1_we_n)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [15:0] init_val(input int i);
      return (i == 16) ? 16'h1234 : 16'(32'hA000 + i);
   endfunction

   always @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else if (!ce_n && !we_n) begin
         mem[sram_addr[7:0]] <= sram_wdata;
      end
   end
   assign sram_rdata    = mem[sram_addr[7:0]];
   assign d1_sram_rdata = 16'hC000 | {4'h0, d1_sram_addr[11:0]};

   always @(negedge Clk) begin
      if (!Reset) begin
         if (cpu_ack && aux_ack) n_overlap++;
         if (!oe_n && !we_n)     n_rw++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // One transaction on one port; caller is 1 time unit after an edge.
   task automatic run_txn(input logic aux, input logic we, input logic [19:0] addr,
                          input logic [15:0] wd, output int lat, output logic [15:0] rd,
                          output int n_oe, output int n_we, output int n_doe,
                          output int n_other, output logic [19:0] s_addr,
                          output logic [15:0] s_wd);
      lat = -1; rd = '0; n_oe = 0; n_we = 0; n_doe = 0; n_other = 0;
      s_addr = '0; s_wd = '0;
      if (aux) begin aux_req = 1; aux_we = we; aux_addr = addr; aux_wdata = wd; end
      else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
      for (int n = 1; n <= 20; n++) begin
         @(posedge Clk); #1;
         if (!oe_n) n_oe++;
         if (!we_n) n_we++;
         if (sram_data_oe) n_doe++;
         if (n == 1) begin s_addr = sram_addr; s_wd = sram_wdata; end
         if (aux ? cpu_ack : aux_ack) n_other++;
         if (aux ? aux_ack : cpu_ack) begin
            lat = n;
            rd  = aux ? aux_rdata : cpu_rdata;
            break;
         end
      end
      @(posedge Clk); #1;
      cpu_req = 0; aux_req = 0;
   endtask

   // Both ports request reads together; returns each port's ack cycle.
   task automatic tie_run(output int c_cpu, output int c_aux,
                          output logic [15:0] d_cpu, output logic [15:0] d_aux);
      logic dc, da;
      c_cpu = -1; c_aux = -1; dc = 0; da = 0; d_cpu = '0; d_aux = '0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
      aux_req = 1; aux_we = 0; aux_addr = 20'h00011;
      for (int n = 1; n <= 30; n++) begin
         @(posedge Clk); #1;
         if (dc) begin cpu_req = 0; dc = 0; end
         if (da) begin aux_req = 0; da = 0; end
         if (cpu_ack && c_cpu < 0) begin c_cpu = n; d_cpu = cpu_rdata; dc = 1; end
         if (aux_ack && c_aux < 0) begin c_aux = n; d_aux = aux_rdata; da = 1; end
         if (c_cpu >= 0 && c_aux >= 0 && !cpu_req && !aux_req) break;
      end
      cpu_req = 0; aux_req = 0;
   endtask

   typedef struct {
      logic        aux;
      logic        we;
      logic [19:0] addr;
      logic [15:0] wd;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vt [9];

   initial begin
      int          lat, n_oe, n_we, n_doe, n_other, c1, c2;
      logic [15:0] rd, s_wd, d1v, d2v, cpu_exp, aux_exp;
      logic [19:0] s_addr;
      logic [15:0] ref_mem [0:255];

      vt[0] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 16'h1234};
      vt[1] = '{1'b1, 1'b1, 20'h00020, 16'hBEEF, 16'h0000};
      vt[2] = '{1'b0, 1'b0, 20'h00020, 16'h0000, 16'hBEEF};
      vt[3] = '{1'b1, 1'b0, 20'h00010, 16'h0000, 16'h1234};
      vt[4] = '{1'b0, 1'b1, 20'h000FF, 16'h0001, 16'h0000};
      vt[5] = '{1'b1, 1'b0, 20'h000FF, 16'h0000, 16'h0001};
      vt[6] = '{1'b1, 1'b1, 20'h00020, 16'hFFFF, 16'h0000};
      vt[7] = '{1'b0, 1'b0, 20'h00020, 16'h0000, 16'hFFFF};
      vt[8] = '{1'b1, 1'b0, 20'h00000, 16'h0000, 16'hA000};

      Reset = 1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
      d1_cpu_req = 0; d1_cpu_we = 0; d1_cpu_addr = '0; d1_cpu_wdata = '0;
      d1_aux_req = 0; d1_aux_we = 0; d1_aux_addr = '0; d1_aux_wdata = '0;
      repeat (2) @(posedge Clk);
      #1;
      // reset state
      chk("rst_ce_n", ce_n, 1);
      chk("rst_oe_n", oe_n, 1);
      chk("rst_we_n", we_n, 1);
      chk("rst_data_oe", sram_data_oe, 0);
      chk("rst_acks", {cpu_ack, aux_ack}, 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_rdata", {cpu_rdata, aux_rdata}, 0);
      Reset = 0;
      @(posedge Clk); #1;

      // table of single transactions
      cpu_exp = '0; aux_exp = '0;
      for (int i = 0; i < 9; i++) begin
         run_txn(vt[i].aux, vt[i].we, vt[i].addr, vt[i].wd,
                 lat, rd, n_oe, n_we, n_doe, n_other, s_addr, s_wd);
         chk($sformatf("v%0d_latency", i), lat, 4);
         chk($sformatf("v%0d_other_ack", i), n_other, 0);
         chk($sformatf("v%0d_sram_addr", i), s_addr, vt[i].addr);
         if (vt[i].we) begin
            chk($sformatf("v%0d_we_cycles", i), n_we, 3);
            chk($sformatf("v%0d_doe_cycles", i), n_doe, 4);
            chk($sformatf("v%0d_oe_cycles", i), n_oe, 0);
            chk($sformatf("v%0d_sram_wdata", i), s_wd, vt[i].wd);
         end else begin
            chk($sformatf("v%0d_oe_cycles", i), n_oe, 3);
            chk($sformatf("v%0d_we_cycles", i), n_we, 0);
            chk($sformatf("v%0d_doe_cycles", i), n_doe, 0);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
            if (vt[i].aux) aux_exp = vt[i].exp_rd;
            else           cpu_exp = vt[i].exp_rd;
         end
         // the port that was not served keeps its read data
         if (vt[i].aux) chk($sformatf("v%0d_cpu_rdata_kept", i), cpu_rdata, cpu_exp);
         else           chk($sformatf("v%0d_aux_rdata_kept", i), aux_rdata, aux_exp);
      end

      // reset in cycle 2 of a CPU read
      cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Reset = 1; cpu_req = 0;
      @(posedge Clk); #1;
      chk("midrst_ce_n", ce_n, 1);
      chk("midrst_oe_n", oe_n, 1);
      chk("midrst_cpu_rdata", cpu_rdata, 0);
      chk("midrst_state", 32'(u_dut.r_state), 0);
      Reset = 0;
      c1 = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge Clk); #1;
         if (cpu_ack || aux_ack) c1++;
      end
      chk("midrst_no_ack", c1, 0);
      run_txn(1'b0, 1'b0, 20'h00010, 16'h0, lat, rd, n_oe, n_we, n_doe, n_other, s_addr, s_wd);
      chk("midrst_after_latency", lat, 4);
      chk("midrst_after_rdata", rd, 16'h1234);

      // ties: CPU first after reset, then alternation
      Reset = 1;
      @(posedge Clk); #1;
      Reset = 0;
      tie_run(c1, c2, d1v, d2v);
      chk("tie1_cpu_ack_cycle", c1, 4);
      chk("tie1_aux_ack_cycle", c2, 9);
      chk("tie1_cpu_rdata", d1v, 16'h1234);
      chk("tie1_aux_rdata", d2v, 16'hA011);
      tie_run(c1, c2, d1v, d2v);
      chk("tie2_aux_ack_cycle", c2, 4);
      chk("tie2_cpu_ack_cycle", c1, 9);

      // random two-port traffic against a reference memory
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      begin
         int c_ph, a_ph, c_age, a_age, c_iss, a_iss, c_ack_n, a_ack_n;
         logic c_hold, a_hold, c_w, a_w;
         logic [7:0] c_ad, a_ad;
         logic [15:0] c_wd, a_wd;
         c_ph = 0; a_ph = 0; c_age = 0; a_age = 0;
         c_iss = 0; a_iss = 0; c_ack_n = 0; a_ack_n = 0;
         c_w = 0; a_w = 0; c_ad = '0; a_ad = '0; c_wd = '0; a_wd = '0;
         for (int cyc = 0; cyc < 700; cyc++) begin
            @(posedge Clk); #1;
            if (c_ph == 2) begin cpu_req = 0; c_ph = 0; c_hold = 1; end else c_hold = 0;
            if (a_ph == 2) begin aux_req = 0; a_ph = 0; a_hold = 1; end else a_hold = 0;
            if (cpu_ack) begin
               if (c_ph != 1) begin
                  checks++; errors++;
                  $display("FAIL rnd_cpu_unexpected_ack: got ack=1 want 0 at cycle %0d", cyc);
               end else begin
                  if (c_w) ref_mem[c_ad] = c_wd;
                  else     chk("rnd_cpu_rdata", cpu_rdata, ref_mem[c_ad]);
                  c_ack_n++; c_ph = 2;
               end
            end
            if (aux_ack) begin
               if (a_ph != 1) begin
                  checks++; errors++;
                  $display("FAIL rnd_aux_unexpected_ack: got ack=1 want 0 at cycle %0d", cyc);
               end else begin
                  if (a_w) ref_mem[a_ad] = a_wd;
                  else     chk("rnd_aux_rdata", aux_rdata, ref_mem[a_ad]);
                  a_ack_n++; a_ph = 2;
               end
            end
            if (c_ph == 0 && !c_hold && cyc < 500 && $urandom_range(0, 1) == 1) begin
               c_w = 1'($urandom_range(0, 1)); c_ad = 8'(8'h30 + $urandom_range(0, 15));
               c_wd = 16'($urandom);
               cpu_req = 1; cpu_we = c_w; cpu_addr = {12'h0, c_ad}; cpu_wdata = c_wd;
               c_ph = 1; c_age = 0; c_iss++;
            end
            if (a_ph == 0 && !a_hold && cyc < 500 && $urandom_range(0, 1) == 1) begin
               a_w = 1'($urandom_range(0, 1)); a_ad = 8'(8'h30 + $urandom_range(0, 15));
               a_wd = 16'($urandom);
               aux_req = 1; aux_we = a_w; aux_addr = {12'h0, a_ad}; aux_wdata = a_wd;
               a_ph = 1; a_age = 0; a_iss++;
            end
            if (c_ph == 1) begin
               c_age++;
               if (c_age > 16) begin
                  checks++; errors++;
                  $display("FAIL rnd_cpu_timeout: got no ack in %0d cycles want <= 16", c_age);
                  cpu_req = 0; c_ph = 0;
               end
            end
            if (a_ph == 1) begin
               a_age++;
               if (a_age > 16) begin
                  checks++; errors++;
                  $display("FAIL rnd_aux_timeout: got no ack in %0d cycles want <= 16", a_age);
                  aux_req = 0; a_ph = 0;
               end
            end
         end
         cpu_req = 0; aux_req = 0;
         chk("rnd_cpu_acks_vs_issued", c_ack_n, c_iss);
         chk("rnd_aux_acks_vs_issued", a_ack_n, a_iss);
      end

      // WAIT_CYCLES=1 build: back-to-back CPU reads of 0x1 then 0x2
      begin
         int acks [2];
         logic [15:0] dat [2];
         int got, n_oe1;
         logic pend;
         acks[0] = -1; acks[1] = -1; dat[0] = '0; dat[1] = '0;
         got = 0; n_oe1 = 0; pend = 0;
         d1_cpu_req = 1; d1_cpu_we = 0; d1_cpu_addr = 20'h00001;
         for (int n = 1; n <= 20; n++) begin
            @(posedge Clk); #1;
            if (pend) begin
               if (got == 1) d1_cpu_addr = 20'h00002;
               else          d1_cpu_req = 0;
               pend = 0;
            end
            if (!d1_oe_n) n_oe1++;
            if (d1_cpu_ack) begin
               if (got < 2) begin acks[got] = n; dat[got] = d1_cpu_rdata; end
               got++; pend = 1;
            end
            if (got >= 2 && !d1_cpu_req) break;
         end
         d1_cpu_req = 0;
         chk("w1_ack_count", got, 2);
         chk("w1_ack0_cycle", acks[0], 2);
         chk("w1_ack1_cycle", acks[1], 5);
         chk("w1_rdata0", dat[0], 16'hC001);
         chk("w1_rdata1", dat[1], 16'hC002);
         chk("w1_oe_cycles", n_oe1, 2);
      end

      chk("ack_overlap_cycles", n_overlap, 0);
      chk("oe_we_overlap_cycles", n_rw, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
